// File: rtl/sys_mem_ctrl.sv
// Request sequencer in front of the 64x8 system memory: single/burst read,
// fill-write and erase, holding each access for the memory's fixed latencies.
module sys_mem_ctrl #(
  parameter int RD_HOLD = 2,
  parameter int WR_HOLD = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_op,
  input  logic [5:0] req_adrs,
  input  logic [3:0] req_len,
  input  logic [7:0] req_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       busy,
  output logic [5:0] mem_adrs,
  output logic       mem_mode,
  output logic [7:0] mem_data,
  output logic       mem_erase,
  input  logic [7:0] mem_out
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_ERASE = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_ERASE = 2'b10;

  localparam int HOLD_MAX = (RD_HOLD > WR_HOLD) ? RD_HOLD : WR_HOLD;
  localparam int HW       = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  // A beat's byte is captured RD_HOLD+1 edges after its address is issued.
  localparam int TAG_W    = RD_HOLD + 1;

  logic [2:0]       r_state;
  logic [3:0]       r_len;
  logic [HW-1:0]    r_hold;
  logic [TAG_W-1:0] r_tag;
  logic [5:0]       r_mem_adrs;
  logic             r_mem_mode;
  logic [7:0]       r_mem_data;
  logic             r_mem_erase;
  logic             r_rsp_valid;
  logic [7:0]       r_rsp_data;

  logic w_hold_done;
  logic w_more;
  logic w_issue;

  assign w_hold_done = (r_hold == '0);
  assign w_more      = (r_len != '0);
  assign w_issue     = ((r_state == S_IDLE) && req_valid && (req_op == OP_READ)) ||
                       ((r_state == S_READ) && w_hold_done && w_more);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_len       <= '0;
      r_hold      <= '0;
      r_tag       <= '0;
      r_mem_adrs  <= '0;
      r_mem_mode  <= 1'b0;
      r_mem_data  <= '0;
      r_mem_erase <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      r_tag       <= {r_tag[TAG_W-2:0], w_issue};
      r_rsp_valid <= r_tag[TAG_W-1];
      if (r_tag[TAG_W-1]) begin
        r_rsp_data <= mem_out;
      end

      case (r_state)
        S_IDLE: begin
          r_mem_mode  <= 1'b0;
          r_mem_erase <= 1'b0;
          if (req_valid) begin
            case (req_op)
              OP_READ: begin
                r_mem_adrs <= req_adrs;
                r_len      <= req_len;
                r_hold     <= HW'(RD_HOLD - 1);
                r_state    <= S_READ;
              end
              OP_WRITE: begin
                r_mem_adrs <= req_adrs;
                r_mem_data <= req_data;
                r_mem_mode <= 1'b1;
                r_len      <= req_len;
                r_hold     <= HW'(WR_HOLD - 1);
                r_state    <= S_WRITE;
              end
              OP_ERASE: begin
                r_mem_erase <= 1'b1;
                r_state     <= S_ERASE;
              end
              default: begin
              end
            endcase
          end
        end

        S_READ: begin
          if (!w_hold_done) begin
            r_hold <= r_hold - 1'b1;
          end else if (w_more) begin
            r_mem_adrs <= r_mem_adrs + 6'd1;
            r_len      <= r_len - 4'd1;
            r_hold     <= HW'(RD_HOLD - 1);
          end else begin
            r_state <= S_DRAIN;
          end
        end

        S_WRITE: begin
          if (!w_hold_done) begin
            r_hold <= r_hold - 1'b1;
          end else if (w_more) begin
            r_mem_adrs <= r_mem_adrs + 6'd1;
            r_len      <= r_len - 4'd1;
            r_hold     <= HW'(WR_HOLD - 1);
          end else begin
            r_mem_mode <= 1'b0;
            r_state    <= S_IDLE;
          end
        end

        S_ERASE: begin
          r_mem_erase <= 1'b0;
          r_state     <= S_IDLE;
        end

        S_DRAIN: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign mem_adrs  = r_mem_adrs;
  assign mem_mode  = r_mem_mode;
  assign mem_data  = r_mem_data;
  assign mem_erase = r_mem_erase;

endmodule
